// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: IDLE/WALK/CLEAR FSM with tick divider and countdown.
// Outputs are registered images of the control state, so they trail it by one cycle.
module ped_crossing_ctrl #(
   parameter int unsigned CNT_W      = 7,
   parameter int unsigned WALK_TIME  = 10,
   parameter int unsigned CLEAR_TIME = 20,
   parameter int unsigned TICK_DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             button,
   input  logic             grant,
   output logic             walk_light,
   output logic             hand_light,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             ped_request,
   output logic             cycle_done
);

   localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {StIdle, StWalk, StClear} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [DivW-1:0]   div_q, div_d;
   logic              flash_q, flash_d;
   logic              ped_req_q, ped_req_d;
   logic              done_q, done_d;

   logic              walk_q, walk_d;
   logic              hand_q, hand_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              count_valid_q, count_valid_d;
   logic              cycle_done_q, cycle_done_d;

   logic              tick;
   logic              expire;

   assign tick   = (div_q == DivW'(TICK_DIV - 1));
   // grant=0 and the final tick lead to the same next state, so no extra arbitration is needed
   assign expire = !grant || (tick && (timer_q == CNT_W'(1)));

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      div_d     = tick ? '0 : div_q + DivW'(1);
      flash_d   = flash_q;
      ped_req_d = ped_req_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            div_d   = '0;
            timer_d = '0;
            if (button) ped_req_d = 1'b1;
            if ((ped_req_q || button) && grant) begin
               state_d   = StWalk;
               timer_d   = CNT_W'(WALK_TIME);
               ped_req_d = 1'b0;
            end
         end
         StWalk: begin
            if (expire) begin
               state_d = StClear;
               timer_d = CNT_W'(CLEAR_TIME);
               div_d   = '0;
               flash_d = 1'b1;
            end else if (tick) begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         StClear: begin
            if (button) ped_req_d = 1'b1;
            if (tick) flash_d = ~flash_q;
            if (expire) begin
               state_d = StIdle;
               timer_d = '0;
               div_d   = '0;
               flash_d = 1'b1;
               done_d  = 1'b1;
            end else if (tick) begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
            div_d   = '0;
         end
      endcase
   end

   always_comb begin
      walk_d        = (state_q == StWalk);
      hand_d        = (state_q == StClear) ? flash_q : (state_q != StWalk);
      count_d       = (state_q == StClear) ? timer_q : '0;
      count_valid_d = (state_q == StClear);
      cycle_done_d  = done_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         div_q         <= '0;
         flash_q       <= 1'b1;
         ped_req_q     <= 1'b0;
         done_q        <= 1'b0;
         walk_q        <= 1'b0;
         hand_q        <= 1'b1;
         count_q       <= '0;
         count_valid_q <= 1'b0;
         cycle_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         div_q         <= div_d;
         flash_q       <= flash_d;
         ped_req_q     <= ped_req_d;
         done_q        <= done_d;
         walk_q        <= walk_d;
         hand_q        <= hand_d;
         count_q       <= count_d;
         count_valid_q <= count_valid_d;
         cycle_done_q  <= cycle_done_d;
      end
   end

   assign walk_light  = walk_q;
   assign hand_light  = hand_q;
   assign count       = count_q;
   assign count_valid = count_valid_q;
   assign ped_request = ped_req_q;
   assign cycle_done  = cycle_done_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl; each step queues the expected output word and checks it.
module tb_ped_crossing_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       button = 1'b0;
   logic       grant = 1'b0;
   logic       walk_light;
   logic       hand_light;
   logic [6:0] count;
   logic       count_valid;
   logic       ped_request;
   logic       cycle_done;

   logic [11:0] exp_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   ped_crossing_ctrl #(
      .CNT_W     (7),
      .WALK_TIME (3),
      .CLEAR_TIME(4),
      .TICK_DIV  (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .button     (button),
      .grant      (grant),
      .walk_light (walk_light),
      .hand_light (hand_light),
      .count      (count),
      .count_valid(count_valid),
      .ped_request(ped_request),
      .cycle_done (cycle_done)
   );

   // Packed as {walk, hand, count[6:0], count_valid, ped_request, cycle_done}
   function automatic logic [11:0] e_idle(input bit r, input bit d);
      return {1'b0, 1'b1, 7'd0, 1'b0, r, d};
   endfunction

   function automatic logic [11:0] e_walk();
      return {1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0};
   endfunction

   function automatic logic [11:0] e_clr(input int c, input bit h, input bit r);
      return {1'b0, h, 7'(c), 1'b1, r, 1'b0};
   endfunction

   // Drive one cycle of inputs; check the outputs that appear after the sampling edge.
   task automatic cyc(input string tag, input logic b, input logic g, input logic rst,
                      input logic [11:0] e);
      logic [11:0] obs;
      logic [11:0] want;
      exp_q.push_back(e);
      button = b;
      grant  = g;
      reset  = rst;
      @(posedge clk);
      #1;
      obs = {walk_light, hand_light, count, count_valid, ped_request, cycle_done};
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         want = exp_q.pop_front();
         assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (walk,hand,count,cv,req,done)",
                   tag, obs, want);
         end
      end
   endtask

   task automatic walks(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b1, 1'b0, e_walk());
   endtask

   task automatic clear_full(input string tag);
      for (int i = 0; i < 8; i++)
         cyc(tag, 1'b0, 1'b1, 1'b0, e_clr(4 - i / 2, (i % 4) < 2, 1'b0));
   endtask

   initial begin
      cyc("reset", 1'b0, 1'b1, 1'b1, e_idle(1'b0, 1'b0));
      cyc("reset", 1'b0, 1'b1, 1'b1, e_idle(1'b0, 1'b0));

      // Full cycle with a one-cycle button pulse
      cyc("full_req", 1'b1, 1'b1, 1'b0, e_idle(1'b0, 1'b0));
      walks("full_walk", 6);
      clear_full("full_clear");
      cyc("full_done", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b1));
      cyc("full_idle", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b0));

      // Early termination; button held through WALK must not latch a request
      cyc("early_req", 1'b1, 1'b1, 1'b0, e_idle(1'b0, 1'b0));
      for (int i = 0; i < 3; i++) cyc("early_walk_btn", 1'b1, 1'b1, 1'b0, e_walk());
      cyc("early_gdrop", 1'b0, 1'b0, 1'b0, e_walk());
      clear_full("early_clear");
      cyc("early_done", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b1));
      cyc("early_idle", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b0));

      // Button in CLEAR, abort at count 2, re-entry after one IDLE cycle
      cyc("abort_req", 1'b1, 1'b1, 1'b0, e_idle(1'b0, 1'b0));
      walks("abort_walk", 6);
      cyc("abort_c4", 1'b0, 1'b1, 1'b0, e_clr(4, 1'b1, 1'b0));
      cyc("abort_btn", 1'b1, 1'b1, 1'b0, e_clr(4, 1'b1, 1'b1));
      cyc("abort_c3a", 1'b0, 1'b1, 1'b0, e_clr(3, 1'b0, 1'b1));
      cyc("abort_c3b", 1'b0, 1'b1, 1'b0, e_clr(3, 1'b0, 1'b1));
      cyc("abort_gdrop", 1'b0, 1'b0, 1'b0, e_clr(2, 1'b1, 1'b1));
      cyc("abort_done", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b1));
      walks("rewalk", 6);
      clear_full("rewalk_clear");
      cyc("rewalk_done", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b1));
      cyc("rewalk_idle", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b0));

      // Reset mid-CLEAR at count 3
      cyc("rst_req", 1'b1, 1'b1, 1'b0, e_idle(1'b0, 1'b0));
      walks("rst_walk", 6);
      cyc("rst_c4a", 1'b0, 1'b1, 1'b0, e_clr(4, 1'b1, 1'b0));
      cyc("rst_c4b", 1'b0, 1'b1, 1'b0, e_clr(4, 1'b1, 1'b0));
      cyc("rst_c3", 1'b1, 1'b1, 1'b0, e_clr(3, 1'b0, 1'b1));
      cyc("rst_apply", 1'b0, 1'b1, 1'b1, e_idle(1'b0, 1'b0));
      cyc("rst_after", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b0));
      cyc("rst_after2", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b0));

      // Request latched while grant is low, served once grant rises
      cyc("wait_btn", 1'b1, 1'b0, 1'b0, e_idle(1'b1, 1'b0));
      for (int i = 0; i < 4; i++) cyc("wait_hold", 1'b0, 1'b0, 1'b0, e_idle(1'b1, 1'b0));
      cyc("wait_grant", 1'b0, 1'b1, 1'b0, e_idle(1'b0, 1'b0));
      cyc("wait_walk", 1'b0, 1'b0, 1'b0, e_walk());
      cyc("wait_clr", 1'b0, 1'b0, 1'b0, e_clr(4, 1'b1, 1'b0));
      cyc("wait_done", 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b1));
      cyc("wait_idle", 1'b0, 1'b0, 1'b0, e_idle(1'b0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
